// File: rtl/cache_control_if.sv
// Bus between the cache sequencing FSM and the rest of the cache: CPU
// request/response, cacheline adaptor handshake, datapath status and all
// datapath control strobes and mux selects.
//
// Handshake semantics: mem_read/mem_write are held by the CPU until the
// one-cycle mem_resp pulse. pmem_read/pmem_write are held by the controller
// until the one-cycle pmem_resp pulse and drop in the following cycle.
interface cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  logic hit;
  logic dirty;
  logic rd_valid;
  logic rd_tag;
  logic rd_dirty;
  logic rd_lru;
  logic rd_data;
  logic ld_valid;
  logic ld_tag;
  logic ld_dirty;
  logic ld_lru;
  logic ld_data;
  logic load_cpu;
  logic load_pmem;
  logic datain_mux_sel;
  logic addr_mux_sel;
  logic fill_all;
  logic dirty_in;
  logic valid_in;

  // Controller side
  modport master (
    input  mem_read, mem_write, pmem_resp, hit, dirty,
    output mem_resp, pmem_read, pmem_write,
    output rd_valid, rd_tag, rd_dirty, rd_lru, rd_data,
    output ld_valid, ld_tag, ld_dirty, ld_lru, ld_data,
    output load_cpu, load_pmem, datain_mux_sel, addr_mux_sel,
    output fill_all, dirty_in, valid_in
  );

  // CPU / adaptor / datapath side
  modport slave (
    output mem_read, mem_write, pmem_resp, hit, dirty,
    input  mem_resp, pmem_read, pmem_write,
    input  rd_valid, rd_tag, rd_dirty, rd_lru, rd_data,
    input  ld_valid, ld_tag, ld_dirty, ld_lru, ld_data,
    input  load_cpu, load_pmem, datain_mux_sel, addr_mux_sel,
    input  fill_all, dirty_in, valid_in
  );
endinterface

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back cache datapath. Decodes CPU
// requests, samples hit/dirty in CHECK, runs write-back and allocate
// transfers and keeps saturating hit/miss/write-back counters.
//
// Control outputs are decoded from the state register and the same-cycle
// hit/dirty/pmem_resp inputs: a hit must complete in its CHECK cycle and the
// fill strobes belong to the pmem_resp cycle, so they cannot be registered.
// All outputs are gated by rst so they fall to 0 the moment reset asserts.
module cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_control_if.master  bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    RELOAD    = 3'd4
  } state_t;

  state_t state;
  logic   retry;     // current CHECK is the post-fill retry, not a new lookup
  logic   req;
  logic   is_write;  // both requests together are treated as a read

  assign req       = bus.mem_read | bus.mem_write;
  assign is_write  = bus.mem_write & ~bus.mem_read;
  assign fsm_state = state;

  // State sequencing and saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      retry    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) state <= CHECK;
        end
        CHECK: begin
          retry <= 1'b0;
          if (bus.hit) begin
            state <= IDLE;
            if (!retry && hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
            state <= bus.dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            state <= ALLOCATE;
            if (wb_cnt != {CNT_W{1'b1}}) wb_cnt <= wb_cnt + 1'b1;
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) state <= RELOAD;
        end
        RELOAD: begin
          state <= CHECK;
          retry <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control strobe decode; everything not named for a state stays 0
  always_comb begin
    bus.mem_resp       = 1'b0;
    bus.pmem_read      = 1'b0;
    bus.pmem_write     = 1'b0;
    bus.rd_valid       = 1'b0;
    bus.rd_tag         = 1'b0;
    bus.rd_dirty       = 1'b0;
    bus.rd_lru         = 1'b0;
    bus.rd_data        = 1'b0;
    bus.ld_valid       = 1'b0;
    bus.ld_tag         = 1'b0;
    bus.ld_dirty       = 1'b0;
    bus.ld_lru         = 1'b0;
    bus.ld_data        = 1'b0;
    bus.load_cpu       = 1'b0;
    bus.load_pmem      = 1'b0;
    bus.datain_mux_sel = 1'b0;
    bus.addr_mux_sel   = 1'b0;
    bus.fill_all       = 1'b0;
    bus.dirty_in       = 1'b0;
    bus.valid_in       = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE, RELOAD: begin
          bus.rd_valid = 1'b1;
          bus.rd_tag   = 1'b1;
          bus.rd_dirty = 1'b1;
          bus.rd_lru   = 1'b1;
          bus.rd_data  = 1'b1;
        end
        CHECK: begin
          if (bus.hit) begin
            bus.mem_resp = 1'b1;
            bus.ld_lru   = 1'b1;
            if (is_write) begin
              bus.ld_data        = 1'b1;
              bus.datain_mux_sel = 1'b1;
              bus.ld_dirty       = 1'b1;
              bus.dirty_in       = 1'b1;
            end else begin
              bus.load_cpu = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write   = 1'b1;
          bus.load_pmem    = 1'b1;
          bus.addr_mux_sel = 1'b1;
        end
        ALLOCATE: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.ld_data  = 1'b1;
            bus.fill_all = 1'b1;
            bus.ld_tag   = 1'b1;
            bus.ld_valid = 1'b1;
            bus.valid_in = 1'b1;
            bus.ld_dirty = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control. Each request is expanded from the
// controller's documented phase rules into an expected per-cycle output
// trace (exp_q); the adaptor and datapath responses are scheduled open-loop
// from the same phase list. Counters are checked against an event-count
// model with saturation at 2^CNT_W-1.
module tb_cache_control;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // Output vector bit positions
  localparam int B_MEM_RESP = 19, B_PMEM_RD = 18, B_PMEM_WR = 17;
  localparam int B_RD_VALID = 16, B_RD_TAG = 15, B_RD_DIRTY = 14, B_RD_LRU = 13, B_RD_DATA = 12;
  localparam int B_LD_VALID = 11, B_LD_TAG = 10, B_LD_DIRTY = 9, B_LD_LRU = 8, B_LD_DATA = 7;
  localparam int B_LOAD_CPU = 6, B_LOAD_PMEM = 5, B_DIN_SEL = 4, B_ADDR_SEL = 3;
  localparam int B_FILL_ALL = 2, B_DIRTY_IN = 1, B_VALID_IN = 0;

  // Request phases
  localparam int PH_IDLE = 0, PH_HIT = 1, PH_MISS = 2, PH_WB = 3, PH_WB_RESP = 4;
  localparam int PH_AL = 5, PH_AL_RESP = 6, PH_RELOAD = 7;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;
  logic [2:0]       fsm_state;

  int errors = 0;
  int checks = 0;
  int m_hit, m_miss, m_wb;

  cache_control_if bus ();

  cache_control #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt),
    .fsm_state (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] obs_vec();
    return {bus.mem_resp, bus.pmem_read, bus.pmem_write,
            bus.rd_valid, bus.rd_tag, bus.rd_dirty, bus.rd_lru, bus.rd_data,
            bus.ld_valid, bus.ld_tag, bus.ld_dirty, bus.ld_lru, bus.ld_data,
            bus.load_cpu, bus.load_pmem, bus.datain_mux_sel, bus.addr_mux_sel,
            bus.fill_all, bus.dirty_in, bus.valid_in};
  endfunction

  // Expected outputs for one cycle of a given phase
  function automatic logic [19:0] phase_vec(input int ph, input bit wr);
    logic [19:0] v;
    v = '0;
    case (ph)
      PH_IDLE, PH_RELOAD: begin
        v[B_RD_VALID] = 1'b1; v[B_RD_TAG] = 1'b1; v[B_RD_DIRTY] = 1'b1;
        v[B_RD_LRU] = 1'b1; v[B_RD_DATA] = 1'b1;
      end
      PH_HIT: begin
        v[B_MEM_RESP] = 1'b1; v[B_LD_LRU] = 1'b1;
        if (wr) begin
          v[B_LD_DATA] = 1'b1; v[B_DIN_SEL] = 1'b1; v[B_LD_DIRTY] = 1'b1; v[B_DIRTY_IN] = 1'b1;
        end else begin
          v[B_LOAD_CPU] = 1'b1;
        end
      end
      PH_WB, PH_WB_RESP: begin
        v[B_PMEM_WR] = 1'b1; v[B_LOAD_PMEM] = 1'b1; v[B_ADDR_SEL] = 1'b1;
      end
      PH_AL: v[B_PMEM_RD] = 1'b1;
      PH_AL_RESP: begin
        v[B_PMEM_RD] = 1'b1; v[B_LD_DATA] = 1'b1; v[B_FILL_ALL] = 1'b1; v[B_LD_TAG] = 1'b1;
        v[B_LD_VALID] = 1'b1; v[B_VALID_IN] = 1'b1; v[B_LD_DIRTY] = 1'b1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed away from the clock edge
  task automatic do_reset();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    #2 rst = 1'b0;
    m_hit = 0; m_miss = 0; m_wb = 0;
    #3 rst = 1'b1;
    tick();
  endtask

  // Idle cycles with no request: only the array read strobes are expected
  task automatic idle_gap(input int n);
    logic [19:0] got;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.hit = 1'($urandom_range(0, 1));
      bus.dirty = 1'($urandom_range(0, 1));
      bus.pmem_resp = 1'($urandom_range(0, 1));
      #1 got = obs_vec();
      checks++;
      if (got !== phase_vec(PH_IDLE, 1'b0)) begin
        errors++;
        $display("FAIL idle_gap cyc %0d: got %h expected %h", k, got, phase_vec(PH_IDLE, 1'b0));
      end
      tick();
    end
  endtask

  // One CPU request from IDLE to mem_resp, checked cycle by cycle
  task automatic run_txn(input bit wr, input bit both, input bit is_hit, input bit dty,
                         input int pw, input int p, input string name);
    logic [19:0] exp_q[$];
    int          ph_q[$];
    logic [19:0] got, exp;
    int          ph;
    bit          wr_eff;
    wr_eff = wr && !both;
    ph_q.push_back(PH_IDLE);
    if (!is_hit) begin
      ph_q.push_back(PH_MISS);
      if (dty) begin
        for (int i = 0; i < pw - 1; i++) ph_q.push_back(PH_WB);
        ph_q.push_back(PH_WB_RESP);
      end
      for (int i = 0; i < p - 1; i++) ph_q.push_back(PH_AL);
      ph_q.push_back(PH_AL_RESP);
      ph_q.push_back(PH_RELOAD);
    end
    ph_q.push_back(PH_HIT);
    foreach (ph_q[i]) exp_q.push_back(phase_vec(ph_q[i], wr_eff));

    bus.mem_read  = !wr || both;
    bus.mem_write = wr || both;
    for (int k = 0; k < ph_q.size(); k++) begin
      ph  = ph_q[k];
      exp = exp_q.pop_front();
      bus.hit   = (ph == PH_HIT) ? 1'b1 : (ph == PH_MISS) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.dirty = (ph == PH_MISS) ? dty : 1'($urandom_range(0, 1));
      if (ph == PH_WB_RESP || ph == PH_AL_RESP) bus.pmem_resp = 1'b1;
      else if (ph == PH_WB || ph == PH_AL)      bus.pmem_resp = 1'b0;
      else                                      bus.pmem_resp = 1'($urandom_range(0, 1));
      #1 got = obs_vec();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cyc %0d phase %0d: got %h expected %h", name, k, ph, got, exp);
      end
      tick();
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;

    if (is_hit) m_hit++;
    else begin
      m_miss++;
      if (dty) m_wb++;
    end
    checks++;
    if (hit_cnt !== CNT_W'(sat(m_hit))) begin
      errors++; $display("FAIL %s hit_cnt: got %0d expected %0d", name, hit_cnt, sat(m_hit));
    end
    checks++;
    if (miss_cnt !== CNT_W'(sat(m_miss))) begin
      errors++; $display("FAIL %s miss_cnt: got %0d expected %0d", name, miss_cnt, sat(m_miss));
    end
    checks++;
    if (wb_cnt !== CNT_W'(sat(m_wb))) begin
      errors++; $display("FAIL %s wb_cnt: got %0d expected %0d", name, wb_cnt, sat(m_wb));
    end
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst = 1'b0;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.hit = 1'b1; bus.dirty = 1'b0; bus.pmem_resp = 1'b0;
    #12;
    got = obs_vec();
    checks++;
    if (got !== 20'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", got); end
    checks++;
    if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", hit_cnt, miss_cnt, wb_cnt);
    end
    checks++;
    if (^fsm_state === 1'bx) begin errors++; $display("FAIL reset_state_known: got %b", fsm_state); end
    bus.mem_read = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    m_hit = 0; m_miss = 0; m_wb = 0;
    tick();
    idle_gap(2);
  endtask

  task automatic test_read_hit();
    do_reset();
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "read_hit");
  endtask

  task automatic test_clean_miss();
    do_reset();
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 0, 5, "clean_read_miss");
  endtask

  task automatic test_dirty_write_miss();
    do_reset();
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 4, 4, "dirty_write_miss");
  endtask

  task automatic test_both_requests();
    do_reset();
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, "both_req_hit");
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 2, 3, "both_req_miss");
  endtask

  task automatic test_reset_mid_wb();
    logic [19:0] got;
    do_reset();
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.pmem_resp = 1'b0;
    bus.hit = 1'b0; bus.dirty = 1'b1;
    #1 got = obs_vec();
    checks++;
    if (got !== phase_vec(PH_IDLE, 1'b1)) begin errors++; $display("FAIL rmw_idle: got %h expected %h", got, phase_vec(PH_IDLE, 1'b1)); end
    tick();
    #1 got = obs_vec();
    checks++;
    if (got !== phase_vec(PH_MISS, 1'b1)) begin errors++; $display("FAIL rmw_check: got %h expected %h", got, phase_vec(PH_MISS, 1'b1)); end
    tick();
    #1 got = obs_vec();
    checks++;
    if (got !== phase_vec(PH_WB, 1'b1)) begin errors++; $display("FAIL rmw_wb: got %h expected %h", got, phase_vec(PH_WB, 1'b1)); end
    checks++;
    if (miss_cnt !== CNT_W'(1)) begin errors++; $display("FAIL rmw_miss_cnt: got %0d expected 1", miss_cnt); end
    tick();
    // Mid-cycle reset while write-back is still pending
    #1 rst = 1'b0;
    #1 got = obs_vec();
    checks++;
    if (got !== 20'h0) begin errors++; $display("FAIL rmw_async_outputs: got %h expected 0", got); end
    checks++;
    if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin
      errors++; $display("FAIL rmw_async_counters: got %0d/%0d/%0d expected 0/0/0", hit_cnt, miss_cnt, wb_cnt);
    end
    tick();
    got = obs_vec();
    checks++;
    if (got !== 20'h0) begin errors++; $display("FAIL rmw_held_outputs: got %h expected 0", got); end
    bus.mem_write = 1'b0; bus.dirty = 1'b0;
    #2 rst = 1'b1;
    m_hit = 0; m_miss = 0; m_wb = 0;
    tick();
    idle_gap(1);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "after_reset_hit");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) run_txn(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "sat_hit");
    checks++;
    if (hit_cnt !== CNT_W'(15)) begin errors++; $display("FAIL saturation: got %0d expected 15", hit_cnt); end
  endtask

  task automatic test_random();
    bit wr, both, is_hit, dty;
    int pw, p;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      wr     = 1'($urandom_range(0, 1));
      both   = ($urandom_range(0, 7) == 0);
      is_hit = 1'($urandom_range(0, 1));
      dty    = 1'($urandom_range(0, 1));
      pw     = $urandom_range(1, 6);
      p      = $urandom_range(1, 6);
      run_txn(wr, both, is_hit, dty, pw, p, "random");
      idle_gap($urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    bus.hit = 1'b0; bus.dirty = 1'b0;
    test_reset();
    test_read_hit();
    test_clean_miss();
    test_dirty_write_miss();
    test_both_requests();
    test_reset_mid_wb();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 2-way, 8-set, 256-bit-line write-back cache datapath. It sits between the CPU-side bus adapter and physical memory. It decodes CPU read/write requests, samples the datapath's hit/dirty status, and drives every load/read strobe and mux select in the datapath. It runs write-back and allocate transfers over the cacheline adaptor handshake and keeps saturating hit/miss/writeback counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low; resets all state and outputs
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle CPU completion pulse
- pmem_read  out  1  line fill request to cacheline adaptor
- pmem_write  out  1  line write-back request to cacheline adaptor
- pmem_resp  in  1  adaptor completion pulse
- hit  in  1  datapath hit status, valid in CHECK
- dirty  in  1  datapath victim-dirty status, valid in CHECK
- rd_valid, rd_tag, rd_dirty, rd_lru, rd_data  out  1 each  array read strobes
- ld_valid, ld_tag, ld_dirty, ld_lru, ld_data  out  1 each  array load strobes
- load_cpu  out  1  drive selected line onto mem_rdata256
- load_pmem  out  1  drive victim line onto pmem_wdata
- datain_mux_sel  out  1  0 = pmem_rdata, 1 = mem_wdata256
- addr_mux_sel  out  1  0 = CPU address to pmem, 1 = victim tag/index address
- fill_all  out  1  forces the datapath byte enable to all ones for a line fill
- dirty_in, valid_in  out  1 each  data written to the dirty/valid arrays
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W each  saturating performance counters

## Operation
- States: IDLE, CHECK, WRITEBACK, ALLOCATE, RELOAD. Reset state is IDLE.
- IDLE:
  - Asserts all rd_* strobes every cycle.
  - On mem_read|mem_write, goes to CHECK. Otherwise stays.
  - If both requests are asserted, the request is treated as a read (illegal per protocol).
- CHECK, hit:
  - Read hit: load_cpu=1, ld_lru=1, mem_resp=1. Next state IDLE. hit_cnt++.
  - Write hit: ld_data=1, datain_mux_sel=1, ld_dirty=1, dirty_in=1, ld_lru=1, mem_resp=1. Next state IDLE. hit_cnt++.
- CHECK, miss: miss_cnt++. If dirty=1, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - Holds pmem_write=1, load_pmem=1, addr_mux_sel=1 until pmem_resp.
  - On pmem_resp: wb_cnt++, next state ALLOCATE.
- ALLOCATE:
  - Holds pmem_read=1, addr_mux_sel=0 until pmem_resp.
  - In the pmem_resp cycle also asserts: ld_data=1, datain_mux_sel=0, fill_all=1, ld_tag=1, ld_valid=1, valid_in=1, ld_dirty=1, dirty_in=0.
  - Next state RELOAD.
- RELOAD: asserts all rd_* strobes. Next state CHECK, which now hits and completes as above (no extra hit_cnt increment for the retry).
- Outputs not listed for a state are 0.
- Counters:
  - Increment by 1 on the stated events.
  - Saturate at 2^CNT_W-1 with no wrap.
  - Clear only on reset.
- The CPU must hold its request, address, and write data from request assertion until mem_resp. The controller does not latch them.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, every output 0, counters 0. Takes effect immediately, mid-transfer included. Any in-flight pmem request is dropped; the adaptor must be reset with it.
- Read hit latency: request seen in IDLE at edge N, CHECK during cycle N+1, mem_resp asserted in cycle N+1. Total 2 cycles.
- Clean miss: 2 + P + 2 cycles, where P is pmem latency counted to the pmem_resp cycle.
- Dirty miss: adds a second pmem latency for the write-back.
- pmem_read and pmem_write are never asserted together. Each is held high continuously until pmem_resp, then drops the next cycle.
- pmem_resp in IDLE, CHECK, or RELOAD is ignored.
- mem_resp is exactly one cycle per request and is never asserted outside CHECK.
- Arrays have registered reads: strobes asserted in cycle N yield data in cycle N+1. The controller never samples hit or dirty in the same cycle it issues the rd_* strobes.

## Test plan
- Read hit: preload set 3 way 0 with valid tag 0x00ABCD, issue read of 0x00ABCD60 -> mem_resp in cycle 2, load_cpu=1, ld_lru=1, no pmem activity, hit_cnt=1.
- Clean read miss, adaptor latency 5 -> pmem_read high exactly 5 cycles, no pmem_write, fill strobes in the pmem_resp cycle, mem_resp 2 cycles later, miss_cnt=1, hit_cnt=0.
- Dirty write miss: victim dirty, latency 4 on both transfers -> pmem_write+load_pmem+addr_mux_sel for 4 cycles, then pmem_read for 4 cycles, then a write hit sets dirty_in=1. wb_cnt=1.
- Reset asserted mid-WRITEBACK -> all outputs 0 asynchronously before the next edge; after release, state IDLE and counters 0.
- Counter saturation with CNT_W=4: issue 20 read hits -> hit_cnt holds 15.
- Simultaneous mem_read and mem_write on a hit -> read behaviour: no ld_data, load_cpu=1.
